// File: rtl/game_pkg.sv
// Shared types and constants for the stacker game sequencing logic.
package game_pkg;

    localparam int unsigned MS_PER_S = 1000;

    typedef enum logic [1:0] {
        GS_IDLE      = 2'b00,
        GS_COUNTDOWN = 2'b01,
        GS_PLAY      = 2'b10,
        GS_OVER      = 2'b11
    } gamestate_t;

    typedef enum logic [1:0] {
        DISP_IDLE  = 2'd0,
        DISP_COUNT = 2'd1,
        DISP_GAME  = 2'd2,
        DISP_SCORE = 2'd3
    } disp_sel_t;

    // LED matrix source for each game state
    function automatic disp_sel_t disp_for_state(input gamestate_t gs);
        case (gs)
            GS_IDLE:      return DISP_IDLE;
            GS_COUNTDOWN: return DISP_COUNT;
            GS_PLAY:      return DISP_GAME;
            default:      return DISP_SCORE;
        endcase
    endfunction

endpackage

// File: rtl/ms_interval_counter.sv
// Millisecond interval counter: counts ms ticks up to a terminal count, then wraps
// and strobes done_c in the same cycle as the qualifying tick.
module ms_interval_counter #(
    parameter int unsigned CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             en_i,
    input  logic             clr_i,
    input  logic [CNT_W-1:0] tc_i,
    output logic             done_c
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over counting; done still reflects the tick so a boundary is never lost
    always_comb begin
        cnt_d  = cnt_q;
        done_c = 1'b0;
        if (tick_i && en_i) begin
            if (cnt_q == tc_i) begin
                done_c = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
        if (clr_i) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_scheduler.sv
// Stacker game sequencer: countdown, level-scaled step pulse, game-over hold, display select.
// Optional pause in PLAY is enabled by defining GAME_SCHED_PAUSE_EN.
module game_scheduler
    import game_pkg::*;
#(
    parameter int unsigned BASE_PERIOD_MS = 1000,
    parameter int unsigned MIN_PERIOD_MS  = 100,
    parameter int unsigned STEP_MS        = 100,
    parameter int unsigned COUNTDOWN_S    = 3,
    parameter int unsigned OVER_HOLD_S    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ms_tick,
    input  logic       start,
    input  logic       level_up,
    input  logic       game_eog,
    output logic [1:0] gamestate,
    output logic       step_pulse,
    output logic [9:0] period_ms,
    output logic [3:0] level,
    output logic [1:0] countdown,
    output logic [1:0] disp_sel,
    output logic       paused
);

    localparam int unsigned CNT_W = 10;
    localparam int unsigned SEC_W = 4;

    gamestate_t       state_q;
    logic             step_q;
    logic [CNT_W-1:0] period_q;
    logic [3:0]       level_q;
    logic [1:0]       countdown_q;
    logic [SEC_W-1:0] sec_q;

    logic             pause_act;
    logic             ctr_clr_c;
    logic             ctr_en_c;
    logic [CNT_W-1:0] ctr_tc_c;
    logic             ctr_done_c;
    logic signed [CNT_W:0] period_dec_s;
    logic [CNT_W-1:0] period_next_c;

`ifdef GAME_SCHED_PAUSE_EN
    logic paused_q;

    // start toggles pause while playing; leaving PLAY always unpauses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            paused_q <= 1'b0;
        end else if (state_q == GS_PLAY) begin
            if (game_eog) begin
                paused_q <= 1'b0;
            end else if (start) begin
                paused_q <= ~paused_q;
            end
        end else begin
            paused_q <= 1'b0;
        end
    end

    assign pause_act = paused_q;
`else
    assign pause_act = 1'b0;
`endif

    // Signed subtract so the floor compare never sees a wrapped value
    assign period_dec_s  = $signed({1'b0, period_q}) - $signed((CNT_W+1)'(STEP_MS));
    assign period_next_c = (period_dec_s < $signed((CNT_W+1)'(MIN_PERIOD_MS)))
                         ? CNT_W'(MIN_PERIOD_MS) : period_dec_s[CNT_W-1:0];

    // Shared ms counter: seconds in COUNTDOWN/OVER, step period in PLAY
    always_comb begin
        ctr_clr_c = 1'b0;
        ctr_en_c  = 1'b0;
        ctr_tc_c  = CNT_W'(MS_PER_S - 1);
        case (state_q)
            GS_IDLE:      ctr_clr_c = 1'b1;
            GS_COUNTDOWN: ctr_en_c  = 1'b1;
            GS_PLAY: begin
                ctr_en_c  = ~pause_act;
                ctr_tc_c  = period_q - CNT_W'(1);
                ctr_clr_c = game_eog | (level_up & ~pause_act);
            end
            GS_OVER:      ctr_en_c  = 1'b1;
            default:      ctr_clr_c = 1'b1;
        endcase
    end

    ms_interval_counter #(
        .CNT_W (CNT_W)
    ) u_ms_cnt (
        .clk    (clk),
        .rst    (rst),
        .tick_i (ms_tick),
        .en_i   (ctr_en_c),
        .clr_i  (ctr_clr_c),
        .tc_i   (ctr_tc_c),
        .done_c (ctr_done_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= GS_IDLE;
            step_q      <= 1'b0;
            period_q    <= CNT_W'(BASE_PERIOD_MS);
            level_q     <= 4'd0;
            countdown_q <= 2'd0;
            sec_q       <= '0;
        end else begin
            step_q <= 1'b0;
            case (state_q)
                GS_IDLE: begin
                    if (start) begin
                        state_q     <= GS_COUNTDOWN;
                        countdown_q <= 2'(COUNTDOWN_S);
                    end
                end
                GS_COUNTDOWN: begin
                    if (ctr_done_c) begin
                        if (countdown_q == 2'd1) begin
                            state_q     <= GS_PLAY;
                            countdown_q <= 2'd0;
                            level_q     <= 4'd0;
                            period_q    <= CNT_W'(BASE_PERIOD_MS);
                        end else begin
                            countdown_q <= countdown_q - 2'd1;
                        end
                    end
                end
                GS_PLAY: begin
                    // End of game outranks both the step and a level-up
                    if (game_eog) begin
                        state_q <= GS_OVER;
                        sec_q   <= '0;
                    end else if (!pause_act) begin
                        step_q <= ctr_done_c;
                        if (level_up) begin
                            if (level_q != 4'hF) begin
                                level_q <= level_q + 4'd1;
                            end
                            period_q <= period_next_c;
                        end
                    end
                end
                GS_OVER: begin
                    if (ctr_done_c) begin
                        if (sec_q == SEC_W'(OVER_HOLD_S - 1)) begin
                            state_q <= GS_IDLE;
                            sec_q   <= '0;
                        end else begin
                            sec_q   <= sec_q + SEC_W'(1);
                        end
                    end
                end
                default: state_q <= GS_IDLE;
            endcase
        end
    end

    assign gamestate  = state_q;
    assign step_pulse = step_q;
    assign period_ms  = period_q;
    assign level      = level_q;
    assign countdown  = countdown_q;
    assign disp_sel   = disp_for_state(state_q);
    assign paused     = pause_act;

endmodule

// File: tb/tb_game_scheduler.sv
// Self-checking bench for game_scheduler: vector table, directed corner sequences,
// and a randomized run compared every cycle against a tick-count reference model.
module tb_game_scheduler;

    localparam int BASE   = 1000;
    localparam int MINP   = 100;
    localparam int STEP   = 100;
    localparam int CD_S   = 3;
    localparam int HOLD_S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ms_tick = 1'b0;
    logic       start = 1'b0;
    logic       level_up = 1'b0;
    logic       game_eog = 1'b0;
    logic [1:0] gamestate;
    logic       step_pulse;
    logic [9:0] period_ms;
    logic [3:0] level;
    logic [1:0] countdown;
    logic [1:0] disp_sel;
    logic       paused;

    int n_cmp = 0;
    int n_bad = 0;
    int n_steps = 0;

    // Reference model: state plus ticks elapsed in the current interval
    logic [1:0] m_gs;
    logic [1:0] m_cd;
    logic       m_step;
    logic       m_paused;
    int         m_el;
    int         m_period;
    int         m_level;

    typedef struct {
        bit         s;
        bit         t;
        bit         lu;
        bit         eog;
        logic [1:0] gs;
        logic [1:0] cd;
        logic       step;
    } vec_t;

    vec_t vecs[4];

    game_scheduler #(
        .BASE_PERIOD_MS (BASE),
        .MIN_PERIOD_MS  (MINP),
        .STEP_MS        (STEP),
        .COUNTDOWN_S    (CD_S),
        .OVER_HOLD_S    (HOLD_S)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ms_tick    (ms_tick),
        .start      (start),
        .level_up   (level_up),
        .game_eog   (game_eog),
        .gamestate  (gamestate),
        .step_pulse (step_pulse),
        .period_ms  (period_ms),
        .level      (level),
        .countdown  (countdown),
        .disp_sel   (disp_sel),
        .paused     (paused)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gs = 2'd0; m_cd = 2'd0; m_step = 1'b0; m_paused = 1'b0;
        m_el = 0; m_period = BASE; m_level = 0;
    endtask

    task automatic model_update(input bit s, input bit t, input bit lu, input bit eog);
        m_step = 1'b0;
        case (m_gs)
            2'd0: begin
                if (s) begin m_gs = 2'd1; m_cd = 2'(CD_S); m_el = 0; end
            end
            2'd1: begin
                if (t) begin
                    m_el++;
                    if (m_el >= CD_S * 1000) begin
                        m_gs = 2'd2; m_cd = 2'd0; m_level = 0; m_period = BASE; m_el = 0;
                    end else begin
                        m_cd = 2'(CD_S - m_el / 1000);
                    end
                end
            end
            2'd2: begin
                if (eog) begin
                    m_gs = 2'd3; m_el = 0; m_paused = 1'b0;
                end else begin
                    if (!m_paused) begin
                        if (t) begin
                            m_el++;
                            if (m_el == m_period) begin m_step = 1'b1; m_el = 0; end
                        end
                        if (lu) begin
                            m_level  = (m_level < 15) ? m_level + 1 : 15;
                            m_period = (m_period - STEP < MINP) ? MINP : m_period - STEP;
                            m_el     = 0;
                        end
                    end
`ifdef GAME_SCHED_PAUSE_EN
                    if (s) m_paused = !m_paused;
`endif
                end
            end
            default: begin
                if (t) begin
                    m_el++;
                    if (m_el == HOLD_S * 1000) begin m_gs = 2'd0; m_el = 0; end
                end
            end
        endcase
    endtask

    task automatic check_cycle();
        n_cmp++;
        if (gamestate !== m_gs || step_pulse !== m_step || period_ms !== 10'(m_period) ||
            level !== 4'(m_level) || countdown !== m_cd || disp_sel !== m_gs || paused !== m_paused) begin
            n_bad++;
            $display("FAIL cycle t=%0t got/exp gs=%0d/%0d step=%0d/%0d period=%0d/%0d level=%0d/%0d cd=%0d/%0d disp=%0d/%0d paused=%0d/%0d",
                     $time, gamestate, m_gs, step_pulse, m_step, period_ms, m_period, level, m_level,
                     countdown, m_cd, disp_sel, m_gs, paused, m_paused);
        end
    endtask

    task automatic cyc(input bit s, input bit t, input bit lu, input bit eog);
        @(negedge clk);
        start = s; ms_tick = t; level_up = lu; game_eog = eog;
        @(posedge clk);
        model_update(s, t, lu, eog);
        #1;
        check_cycle();
        if (step_pulse === 1'b1) n_steps++;
        start = 1'b0; ms_tick = 1'b0; level_up = 1'b0; game_eog = 1'b0;
    endtask

    task automatic run_ticks(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, 1'b0, 1'b0);
            end
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        vecs[0] = '{s:1'b0, t:1'b1, lu:1'b1, eog:1'b1, gs:2'd0, cd:2'd0, step:1'b0};
        vecs[1] = '{s:1'b1, t:1'b0, lu:1'b0, eog:1'b0, gs:2'd1, cd:2'd3, step:1'b0};
        vecs[2] = '{s:1'b1, t:1'b1, lu:1'b0, eog:1'b0, gs:2'd1, cd:2'd3, step:1'b0};
        vecs[3] = '{s:1'b0, t:1'b1, lu:1'b1, eog:1'b1, gs:2'd1, cd:2'd3, step:1'b0};

        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gamestate", 32'(gamestate), 32'd0);
        chk("rst_step", 32'(step_pulse), 32'd0);
        chk("rst_period", 32'(period_ms), 32'd1000);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_countdown", 32'(countdown), 32'd0);
        chk("rst_disp", 32'(disp_sel), 32'd0);
        chk("rst_paused", 32'(paused), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Idle ignores level_up/eog; start enters countdown in 1 clk; start ignored in countdown
        for (int i = 0; i < 4; i++) begin
            cyc(vecs[i].s, vecs[i].t, vecs[i].lu, vecs[i].eog);
            chk($sformatf("vec%0d_gs", i), 32'(gamestate), 32'(vecs[i].gs));
            chk($sformatf("vec%0d_cd", i), 32'(countdown), 32'(vecs[i].cd));
            chk($sformatf("vec%0d_step", i), 32'(step_pulse), 32'(vecs[i].step));
        end

        // Remainder of the 3 s countdown
        run_ticks(CD_S * 1000 - 2, 1'b0);
        chk("play_gs", 32'(gamestate), 32'd2);
        chk("play_disp", 32'(disp_sel), 32'd2);
        chk("play_cd", 32'(countdown), 32'd0);

        // Five steps in 5000 ticks with irregular tick spacing
        n_steps = 0;
        run_ticks(5000, 1'b1);
        chk("steps_5000", 32'(n_steps), 32'd5);

        // level_up on the step boundary: step fires and new period restarts from 0
        n_steps = 0;
        run_ticks(999, 1'b0);
        chk("pre_boundary_steps", 32'(n_steps), 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        chk("boundary_step", 32'(step_pulse), 32'd1);
        chk("boundary_period", 32'(period_ms), 32'd900);
        chk("boundary_level", 32'(level), 32'd1);
        n_steps = 0;
        run_ticks(899, 1'b1);
        chk("after_boundary_nostep", 32'(n_steps), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("after_boundary_step", 32'(step_pulse), 32'd1);

`ifdef GAME_SCHED_PAUSE_EN
        // Pause freezes the count; resume continues from the frozen value
        run_ticks(300, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pause_set", 32'(paused), 32'd1);
        n_steps = 0;
        for (int i = 0; i < 3000; i++) cyc(1'b0, 1'b1, (i % 700) == 5, 1'b0);
        chk("pause_nosteps", 32'(n_steps), 32'd0);
        chk("pause_level", 32'(level), 32'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pause_clear", 32'(paused), 32'd0);
        run_ticks(599, 1'b0);
        chk("resume_nostep", 32'(n_steps), 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("resume_step", 32'(step_pulse), 32'd1);
`endif

        // Remaining level-ups: period floors at 100, level saturates at 15
        for (int k = 2; k <= 25; k++) begin
            int gap;
            gap = int'($urandom_range(0, 30));
            for (int j = 0; j < gap; j++) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            cyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
            chk($sformatf("lu%0d_period", k), 32'(period_ms), 32'((1000 - 100 * k < 100) ? 100 : 1000 - 100 * k));
            chk($sformatf("lu%0d_level", k), 32'(level), 32'((k > 15) ? 15 : k));
        end

        // game_eog beats level_up and the step; hold 2 s then back to idle
        cyc(1'b0, 1'b1, 1'b1, 1'b1);
        chk("eog_gs", 32'(gamestate), 32'd3);
        chk("eog_level", 32'(level), 32'd15);
        chk("eog_disp", 32'(disp_sel), 32'd3);
        chk("eog_step", 32'(step_pulse), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("over_start_ignored", 32'(gamestate), 32'd3);
        run_ticks(HOLD_S * 1000 - 1, 1'b1);
        chk("over_hold", 32'(gamestate), 32'd3);
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        chk("over_to_idle", 32'(gamestate), 32'd0);
        chk("idle_level_kept", 32'(level), 32'd15);
        chk("idle_period_kept", 32'(period_ms), 32'd100);

        // New game reloads level/period; asynchronous reset mid-game
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        run_ticks(CD_S * 1000, 1'b0);
        chk("replay_level", 32'(level), 32'd0);
        chk("replay_period", 32'(period_ms), 32'd1000);
        run_ticks(1234, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_gs", 32'(gamestate), 32'd0);
        chk("async_rst_disp", 32'(disp_sel), 32'd0);
        chk("async_rst_period", 32'(period_ms), 32'd1000);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Randomized run against the reference model
        for (int i = 0; i < 20000; i++) begin
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0,
                $urandom_range(0, 99) == 0, $urandom_range(0, 1999) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_scheduler.md
# game_scheduler

Sequencing controller for the stacker game. It owns the 2-bit `gamestate` that the game core consumes, runs the start countdown, and generates the game step pulse. The step period shortens with each level-up, replacing the fixed one-second pulse. It also selects which source the LED matrix controller displays. It sits between the 1 ms timebase and the game core / LED matrix controller.

## Interface
Parameters:
- BASE_PERIOD_MS, 1000, step period at level 0 (ms)
- MIN_PERIOD_MS, 100, period floor (ms)
- STEP_MS, 100, period decrement per level-up (ms)
- COUNTDOWN_S, 3, countdown length (s)
- OVER_HOLD_S, 2, score display time after game over (s)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- ms_tick  in  1  one-cycle pulse every 1 ms from the existing timebase
- start  in  1  one-cycle debounced start button pulse
- level_up  in  1  one-cycle pulse from the game core on a successful stack
- game_eog  in  1  end-of-game flag from the game core (level)
- gamestate  out  2  00 IDLE, 01 COUNTDOWN, 10 PLAY, 11 OVER
- step_pulse  out  1  one-cycle game step strobe
- period_ms  out  10  current step period
- level  out  4  current level, saturating at 15
- countdown  out  2  seconds remaining while in COUNTDOWN, else 0
- disp_sel  out  2  0 idle pattern, 1 countdown digit, 2 game, 3 score
- paused  out  1  pause flag (see Configuration)

## Operation
- The FSM state register drives `gamestate` directly.
- `disp_sel` is decoded from the registered state only: IDLE→0, COUNTDOWN→1, PLAY→2, OVER→3.
- The 10-bit ms counter `ms_cnt` advances only on cycles where `ms_tick` is high.
- IDLE:
  - On `start`: go to COUNTDOWN, `countdown`=COUNTDOWN_S, `ms_cnt`=0.
  - `level_up` and `game_eog` are ignored.
- COUNTDOWN:
  - When `ms_cnt` reaches 999 on an `ms_tick`: `ms_cnt`=0 and `countdown` decrements.
  - When the decrement takes `countdown` from 1 to 0: go to PLAY, `level`=0, `period_ms`=BASE_PERIOD_MS, `ms_cnt`=0.
  - `start` is ignored.
- PLAY:
  - When `ms_tick` arrives and `ms_cnt`==`period_ms`-1: `step_pulse` is high for one cycle and `ms_cnt`=0.
  - On `level_up`: `level` increments (saturates at 15), `period_ms`=max(`period_ms`−STEP_MS, MIN_PERIOD_MS), `ms_cnt`=0.
  - Subtraction is done 11-bit signed so there is no wrap below 0.
  - If `level_up` coincides with a step boundary, `step_pulse` still fires and the new period takes effect from `ms_cnt`=0.
  - `game_eog` high → OVER, with `ms_cnt`=0. `game_eog` has priority over `level_up` and the step: no step pulse fires and level/period are unchanged in that cycle.
- OVER:
  - Holds for OVER_HOLD_S×1000 ms ticks, using `ms_cnt` plus a seconds counter, then goes to IDLE.
  - `level` and `period_ms` are retained until the next COUNTDOWN→PLAY transition.
  - `start` is ignored.

## Timing
- Reset values: `gamestate`=00, `step_pulse`=0, `period_ms`=BASE_PERIOD_MS, `level`=0, `countdown`=0, `disp_sel`=0, `paused`=0, all counters 0.
- Reset asserted mid-game returns to IDLE immediately (asynchronous).
- All outputs are registered, except `disp_sel`, which is a pure decode of the state register.
- `start`→COUNTDOWN latency: 1 clk.
- First `step_pulse` occurs exactly BASE_PERIOD_MS ms ticks after entering PLAY.
- `step_pulse` asserts in the clk following the qualifying `ms_tick`.

## Configuration
- `GAME_SCHED_PAUSE_EN` defined:
  - `start` in PLAY toggles `paused`.
  - While paused, `ms_cnt` freezes, no `step_pulse` is issued, and `level_up` is ignored.
  - `game_eog` still forces OVER and clears `paused`.
- `GAME_SCHED_PAUSE_EN` undefined: `paused` is tied to 0 and `start` is ignored in PLAY.

## Structure
- Shared package `game_pkg` holds:
  - the `gamestate_t` enum (IDLE/COUNTDOWN/PLAY/OVER, 2-bit encodings above)
  - the `disp_sel_t` codes
  - the constant MS_PER_S=1000
- One sub-module, `ms_interval_counter`:
  - advances on `ms_tick`, with synchronous clear and a terminal-count compare input
  - emits a one-cycle `done` pulse
  - used for both the seconds and the step periods.

## Test plan
- Reset, then `start` pulse: `gamestate` is 01 after 1 clk and `countdown` is 3. After 3000 ms ticks `gamestate`=10 and `disp_sel`=2.
- PLAY with no level_up: `step_pulse` occurs every 1000 ms ticks, exactly one clk wide, 5 pulses in 5000 ticks.
- 12 `level_up` pulses: `period_ms` goes 900, 800 … 100 and stays at 100, `level`=12. Then 13 more pulses: `level` saturates at 15.
- `level_up` and step boundary in the same cycle: `step_pulse` fires, `period_ms` drops by 100, and the next step comes period_ms ticks later.
- `game_eog` together with `level_up`: OVER is entered, `level` is unchanged, `disp_sel`=3. After 2000 ticks the state returns to IDLE.
- With `GAME_SCHED_PAUSE_EN`: `start` in PLAY sets `paused`=1 and no steps occur over 3000 ticks. A second `start` resumes, and the remaining count continues from the frozen `ms_cnt`.
